// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: consumer-side bundle of the UART receive FIFO.
// master (receiver): rx_data/frame_err/parity_err = head entry, valid = non-empty,
//   overrun = drop pulse, drop_count = saturating drops, fill_level = entries; ready in.
// slave (consumer): the mirror image, drives ready.
interface uart_rx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
);
    logic [DATA_BITS-1:0]                rx_data;
    logic                                frame_err;
    logic                                parity_err;
    logic                                valid;
    logic                                ready;
    logic                                overrun;
    logic [7:0]                          drop_count;
    logic [$clog2(FIFO_DEPTH+1)-1:0]     fill_level;

    modport master (
        output rx_data, frame_err, parity_err, valid, overrun, drop_count, fill_level,
        input  ready
    );

    modport slave (
        input  rx_data, frame_err, parity_err, valid, overrun, drop_count, fill_level,
        output ready
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with parity/framing flags, glitch rejection and a receive FIFO.
// clk_50: system clock; reset: async active-low; rx_in: async serial line, idle high;
// bus: head entry (first-word fall-through), valid/ready pop, overrun, drop_count, fill_level.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int FIFO_DEPTH   = 16
) (
    input logic             clk_50,
    input logic             reset,
    input logic             rx_in,
    uart_rx_fifo_if.master  bus
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(DATA_BITS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_BITS + 2;
    localparam logic [TW-1:0] T_FULL   = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_HALF   = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

    typedef enum logic [2:0] {ARM, IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state_q, state_d;
    logic [1:0]           sync_q, sync_d;
    logic [1:0]           prime_q, prime_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [CW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 overrun_q, overrun_d;
    logic [7:0]           drop_q, drop_d;
    logic [AW:0]          wr_q, wr_d, rd_q, rd_d;
    logic [EW-1:0]        mem_q [FIFO_DEPTH];
    logic [EW-1:0]        mem_d [FIFO_DEPTH];
    logic                 rx_s, push, pop, full, empty, accept;
    logic [EW-1:0]        head;

    assign rx_s   = sync_q[1];
    assign empty  = wr_q == rd_q;
    assign full   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop    = !empty && bus.ready;
    assign accept = push && (!full || pop);
    assign head   = empty ? '0 : mem_q[rd_q[AW-1:0]];

    assign bus.valid      = !empty;
    assign bus.rx_data    = head[DATA_BITS-1:0];
    assign bus.parity_err = head[DATA_BITS];
    assign bus.frame_err  = head[DATA_BITS+1];
    assign bus.overrun    = overrun_q;
    assign bus.drop_count = drop_q;
    assign bus.fill_level = wr_q - rd_q;

    always_comb begin
        sync_d  = {sync_q[0], rx_in};
        // The synchroniser resets high, so its output is not trusted in ARM until
        // two real line samples have shifted through.
        prime_d = {prime_q[0], 1'b1};
        state_d = state_q;
        timer_d = timer_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        push    = 1'b0;
        case (state_q)
            ARM: begin
                if (rx_s && prime_q[1]) state_d = IDLE;
            end
            // IDLE is only entered with the line high, so a low rx_s here is a falling edge.
            IDLE: begin
                timer_d = '0;
                if (!rx_s) begin
                    state_d = START;
                    perr_d  = 1'b0;
                end
            end
            START: begin
                if (timer_q == T_HALF) begin
                    timer_d = '0;
                    bit_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (timer_q == T_FULL) begin
                    timer_d = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == LAST_BIT) state_d = (PARITY != 0) ? PAR : STOP;
                end
            end
            PAR: begin
                if (timer_q == T_FULL) begin
                    timer_d = '0;
                    perr_d  = (^{shift_q, rx_s}) ^ (PARITY == 1);
                    state_d = STOP;
                end
            end
            STOP: begin
                if (timer_q == T_FULL) begin
                    push    = 1'b1;
                    state_d = rx_s ? IDLE : ARM;
                end
            end
            default: state_d = ARM;
        endcase
    end

    always_comb begin
        mem_d = mem_q;
        if (accept) mem_d[wr_q[AW-1:0]] = {~rx_s, perr_q, shift_q};
        wr_d      = wr_q + {{AW{1'b0}}, accept};
        rd_d      = rd_q + {{AW{1'b0}}, pop};
        overrun_d = push && !accept;
        drop_d    = (overrun_d && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    end

    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            state_q   <= ARM;
            sync_q    <= 2'b11;
            prime_q   <= 2'b00;
            timer_q   <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            perr_q    <= 1'b0;
            overrun_q <= 1'b0;
            drop_q    <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            prime_q   <= prime_d;
            timer_q   <= timer_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            perr_q    <= perr_d;
            overrun_q <= overrun_d;
            drop_q    <= drop_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
        end
    end

    always_ff @(posedge clk_50) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo with a pop-side scoreboard.
module tb_uart_rx_fifo;
    localparam int CPB   = 16;
    localparam int DB    = 8;
    localparam int DEPTH = 16;

    logic clk_50 = 1'b0;
    logic reset  = 1'b0;
    logic rx0    = 1'b1;
    logic rx2    = 1'b1;

    always #5 clk_50 = ~clk_50;

    uart_rx_fifo_if #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) if0 ();
    uart_rx_fifo_if #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) if2 ();

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(0), .FIFO_DEPTH(DEPTH)) dut0 (
        .clk_50(clk_50), .reset(reset), .rx_in(rx0), .bus(if0)
    );
    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(2), .FIFO_DEPTH(DEPTH)) dut2 (
        .clk_50(clk_50), .reset(reset), .rx_in(rx2), .bus(if2)
    );

    int checks = 0;
    int errors = 0;
    int pops0  = 0;
    int ovs0   = 0;
    int p;
    logic [9:0] sb0[$];
    logic [9:0] sb2[$];
    logic [7:0] d99 = 8'h99;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1: a head seen with valid && ready here is popped at the next edge.
    task automatic cyc();
        if (if0.valid && if0.ready) begin
            pops0++;
            chk("pop0", 32'({if0.frame_err, if0.parity_err, if0.rx_data}),
                sb0.size() != 0 ? 32'(sb0.pop_front()) : 32'hDEAD);
        end
        if (if2.valid && if2.ready)
            chk("pop2", 32'({if2.frame_err, if2.parity_err, if2.rx_data}),
                sb2.size() != 0 ? 32'(sb2.pop_front()) : 32'hDEAD);
        if (if0.overrun) ovs0++;
        @(posedge clk_50);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic bit_out(input bit sel, input logic b);
        if (sel) rx2 = b;
        else rx0 = b;
        repeat (CPB) cyc();
    endtask

    task automatic send0(input logic [7:0] d, input bit expect_push);
        if (expect_push) sb0.push_back({2'b00, d});
        bit_out(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) bit_out(1'b0, d[i]);
        bit_out(1'b0, 1'b1);
    endtask

    // Even parity: error when data plus parity bit hold an odd number of ones.
    task automatic send2(input logic [7:0] d, input logic par);
        sb2.push_back({1'b0, ^{d, par}, d});
        bit_out(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) bit_out(1'b1, d[i]);
        bit_out(1'b1, par);
        bit_out(1'b1, 1'b1);
    endtask

    initial begin
        if0.ready = 1'b1;
        if2.ready = 1'b1;
        repeat (3) @(posedge clk_50);
        #1;
        chk("rst_rx_data", 32'(if0.rx_data), 0);
        chk("rst_frame_err", 32'(if0.frame_err), 0);
        chk("rst_parity_err", 32'(if0.parity_err), 0);
        chk("rst_valid", 32'(if0.valid), 0);
        chk("rst_overrun", 32'(if0.overrun), 0);
        chk("rst_drop", 32'(if0.drop_count), 0);
        chk("rst_fill", 32'(if0.fill_level), 0);
        chk("rst_valid2", 32'(if2.valid), 0);
        reset = 1'b1;
        idle(4);

        p = pops0;
        send0(8'h55, 1'b1);
        send0(8'hA3, 1'b1);
        idle(8);
        chk("clean_pops", 32'(pops0 - p), 2);
        chk("clean_sb_empty", 32'(sb0.size()), 0);

        send2(8'hA3, 1'b0);
        send2(8'hA3, 1'b1);
        idle(8);
        chk("parity_sb_empty", 32'(sb2.size()), 0);

        sb0.push_back({2'b10, 8'h3C});
        bit_out(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) bit_out(1'b0, i inside {2, 3, 4, 5});
        rx0 = 1'b0;
        repeat (2 * CPB) cyc();
        p = pops0;
        rx0 = 1'b1;
        idle(3 * CPB);
        chk("frame_sb_empty", 32'(sb0.size()), 0);
        chk("frame_no_extra", 32'(pops0 - p), 0);
        chk("frame_fill", 32'(if0.fill_level), 0);

        p = pops0;
        rx0 = 1'b0;
        repeat (CPB / 4) cyc();
        rx0 = 1'b1;
        idle(2 * CPB);
        chk("glitch_pops", 32'(pops0 - p), 0);
        chk("glitch_valid", 32'(if0.valid), 0);
        send0(8'h7E, 1'b1);
        idle(8);
        chk("glitch_after_sb", 32'(sb0.size()), 0);

        if0.ready = 1'b0;
        ovs0 = 0;
        for (int i = 0; i < 17; i++) send0(8'(i), i < 16);
        idle(4);
        chk("ovr_fill", 32'(if0.fill_level), 16);
        chk("ovr_pulses", 32'(ovs0), 1);
        chk("ovr_drop", 32'(if0.drop_count), 1);
        chk("ovr_head_hold", 32'(if0.rx_data), 0);
        p = pops0;
        if0.ready = 1'b1;
        idle(20);
        chk("drain_pops", 32'(pops0 - p), 16);
        chk("drain_valid", 32'(if0.valid), 0);
        chk("drain_sb_empty", 32'(sb0.size()), 0);

        if0.ready = 1'b0;
        send0(8'h11, 1'b1);
        send0(8'h22, 1'b1);
        send0(8'h33, 1'b1);
        chk("rst_pre_fill", 32'(if0.fill_level), 3);
        bit_out(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) bit_out(1'b0, d99[i]);
        rx0 = 1'b0;
        reset = 1'b0;
        #1;
        chk("arst_valid", 32'(if0.valid), 0);
        chk("arst_fill", 32'(if0.fill_level), 0);
        chk("arst_rx_data", 32'(if0.rx_data), 0);
        chk("arst_drop", 32'(if0.drop_count), 0);
        chk("arst_frame_err", 32'(if0.frame_err), 0);
        sb0.delete();
        idle(3);
        reset = 1'b1;
        if0.ready = 1'b1;
        p = pops0;
        idle(12 * CPB);
        chk("low_line_pops", 32'(pops0 - p), 0);
        chk("low_line_fill", 32'(if0.fill_level), 0);
        rx0 = 1'b1;
        idle(2 * CPB);
        send0(8'h42, 1'b1);
        idle(8);
        chk("post_rst_pops", 32'(pops0 - p), 1);
        chk("post_rst_sb", 32'(sb0.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

- Parametrised UART receiver with an integrated receive FIFO and per-byte error reporting.
- Successor to the single-byte Arduino UART buffer; sits between the Arduino serial line and downstream consumers on the `clk_50` domain.
- Adds configurable parity, framing/parity error flags stored with each byte, glitch rejection, a FIFO of configurable depth, and overrun accounting.

## Interface

Parameters:
- CLKS_PER_BIT, 434 (50 MHz / 115200): clock cycles per bit; must be ≥ 8.
- DATA_BITS, 8: data bits per frame, range 5–9, LSB first.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- FIFO_DEPTH, 16: entries; power of two, ≥ 2.

Ports:
- clk_50, input, 1: system clock; all logic on its rising edge.
- reset, input, 1: asynchronous, active-low reset.
- rx_in, input, 1: serial line, idle high, asynchronous to clk_50.
- rx_data, output, DATA_BITS: head-of-FIFO data (first-word fall-through).
- frame_err, output, 1: head entry's stop bit was sampled low.
- parity_err, output, 1: head entry failed its parity check; always 0 when PARITY = 0.
- valid, output, 1: FIFO non-empty.
- ready, input, 1: consumer accepts the head entry when valid && ready.
- overrun, output, 1: one-cycle pulse when a received byte is dropped because the FIFO is full.
- drop_count, output, 8: dropped-byte count; saturates at 255; cleared only by reset.
- fill_level, output, $clog2(FIFO_DEPTH+1): current entry count.

## Operation

- rx_in passes through a 2-flop synchroniser, reset value 1. All decoding uses the synchronised signal, rx_s.
- ARM: entered from reset. Leave for IDLE only after rx_s is sampled high, so a line held low through reset never starts a frame.
- IDLE: a falling edge on rx_s moves to START and clears the bit-timer.
- START: at timer = CLKS_PER_BIT/2 − 1, sample rx_s.
  - rx_s high: glitch; return to IDLE with nothing pushed.
  - rx_s low: go to DATA and restart the timer.
- DATA: sample at every timer = CLKS_PER_BIT − 1 (the mid-bit point) into a shift register, LSB first. After DATA_BITS samples:
  - PARITY ≠ 0: go to PAR.
  - PARITY = 0: go to STOP.
- PAR: sample one bit. parity_err_int = 1 when the total count of 1s across data and parity bits is even for odd mode, or odd for even mode.
- STOP: sample at mid-bit. frame_err_int = !rx_s. Push {frame_err_int, parity_err_int, data} into the FIFO in this same cycle.
  - rx_s = 1: go to IDLE. Search resumes mid-stop, which tolerates about ±4% baud mismatch.
  - rx_s = 0 (break / framing error): go to ARM and wait for the line to return high.
- Errored bytes are still pushed; the consumer decides what to do with them.
- FIFO:
  - Circular buffer with read/write pointers one bit wider than the address.
  - Push is accepted when not full, or when full and a pop occurs in the same cycle.
  - A push that is not accepted asserts overrun for one cycle and increments drop_count (saturating). FIFO contents are unchanged.
  - Pop occurs on valid && ready. Popping when empty is impossible because valid = 0.
  - Simultaneous push and pop leaves fill_level unchanged.
- Reset mid-frame: the partial frame is discarded, the FIFO empties, and the FSM returns to ARM.

## Timing

- Reset values: rx_data = 0, frame_err = 0, parity_err = 0, valid = 0, overrun = 0, drop_count = 0, fill_level = 0.
- Synchroniser latency: 2 cycles from an rx_in edge to rx_s.
- Push occurs in the STOP mid-bit sample cycle. valid, rx_data, flags and fill_level update on the next rising edge: 1-cycle latency into the FIFO, with no extra output register.
- rx_data, frame_err and parity_err are stable while valid && !ready. After a pop they show the next entry in the following cycle.
- Back-to-back frames need no idle gap: a start edge is detected from the cycle after the STOP sample.
- overrun is high for exactly the cycle after the rejected push.
- drop_count updates in that same cycle.

## Test plan

- **Clean byte.** PARITY = 0, ready = 1. Send 0x55, then 0xA3, at 115200 baud.
  - valid pulses once per byte.
  - rx_data = 0x55, then 0xA3.
  - frame_err = parity_err = 0.
- **Even parity.** PARITY = 2.
  - Send 0xA3 with parity bit 0: parity_err = 0.
  - Resend 0xA3 with parity bit 1: rx_data = 0xA3 and parity_err = 1.
- **Framing error.** Send 0x3C with the stop bit driven low for 2 bit-times, then high.
  - One entry: rx_data = 0x3C, frame_err = 1.
  - No further entry appears until a new start bit arrives after the line has returned high.
- **Overrun.** FIFO_DEPTH = 16, ready = 0. Send 0x00–0x10 (17 bytes).
  - fill_level = 16.
  - overrun pulses once; drop_count = 1.
  - Raising ready drains 0x00–0x0F in order.
  - valid falls after the 16th pop.
- **Glitch.** Drive a low pulse of CLKS_PER_BIT/4 cycles on an idle line.
  - No push; valid stays 0.
  - A following 0x7E is received correctly.
- **Reset.**
  - Assert reset mid-way through the data bits of 0x99 with 3 entries queued: outputs take their reset values immediately (asynchronous), fill_level = 0.
  - Hold rx_in low across reset release: no frame is received until rx_in goes high.
  - Then send 0x42: it is received correctly.
